// File: rtl/reflet_arb_pkg.sv
// -----------------------------------------------------------------------------
// reflet_arb_pkg
// Shared constants for the reflet bus arbiter:
//   - arbiter state encoding (kept as plain 2-bit constants so legacy code
//     that compares raw state values keeps working)
//   - bus master index constants used for the address/data source select
//   - counter width helper used to size the burst and quantum counters
// -----------------------------------------------------------------------------
package reflet_arb_pkg;

  // Arbiter states
  localparam logic [1:0] ARB_CPU_OWN = 2'd0;
  localparam logic [1:0] ARB_DRAIN   = 2'd1;
  localparam logic [1:0] ARB_M1_OWN  = 2'd2;
  localparam logic [1:0] ARB_RETURN  = 2'd3;

  // Bus master indices
  localparam logic ARB_M_CPU = 1'b0;
  localparam logic ARB_M_1   = 1'b1;

  // Bits needed to hold 0..limit inclusive (never less than one bit).
  function automatic int unsigned arb_cnt_width(input int unsigned limit);
    return (limit < 32'd1) ? 32'd1 : $clog2(limit + 32'd1);
  endfunction

endpackage : reflet_arb_pkg

// File: rtl/reflet_sat_counter.sv
// -----------------------------------------------------------------------------
// reflet_sat_counter
// Up-counter that sticks at LIMIT instead of wrapping. A clear has priority
// over an increment.
//
// Ports:
//   clk        input   system clock
//   rst_n      input   asynchronous active-low reset (count returns to 0)
//   clr_i      input   synchronous clear to 0
//   inc_i      input   increment by one (ignored once at LIMIT)
//   count_o    output  current count, WIDTH bits
//   at_limit_o output  count equals LIMIT
// -----------------------------------------------------------------------------
module reflet_sat_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_limit_o
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc_i && (count_q != LIMIT_W)) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == LIMIT_W);

endmodule : reflet_sat_counter

// File: rtl/reflet_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reflet_bus_arbiter
// Shares the reflet system bus between the CPU (master 0) and a secondary
// master such as a DMA or debug loader (master 1). The CPU is stalled through
// its enable, one drain cycle lets its last access settle, master 1 then owns
// the bus for at most max_burst beats, and a return cycle hands the bus back.
// After every return the CPU keeps the bus for at least cpu_quantum cycles.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   cpu_addr/wdata/we    CPU side of the bus
//   cpu_enable           CPU enable, 0 stalls the CPU
//   m1_req/addr/wdata/we master-1 beat request, held until m1_gnt
//   m1_gnt               master-1 beat accepted this cycle
//   m1_rvalid            read data of the previous accepted read beat valid
//   m1_rdata             bus_rdata passthrough
//   bus_addr/wdata/we    muxed bus towards ROM/RAM/peripherals
//   bus_rdata            OR-combined slave read data (1-cycle latency)
// -----------------------------------------------------------------------------
module reflet_bus_arbiter
  import reflet_arb_pkg::*;
#(
  parameter int unsigned wordsize    = 16,
  parameter int unsigned max_burst   = 8,
  parameter int unsigned cpu_quantum = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_wdata,
  input  logic                cpu_write_en,
  output logic                cpu_enable,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_wdata,
  input  logic                m1_write_en,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [wordsize-1:0] m1_rdata,
  output logic [wordsize-1:0] bus_addr,
  output logic [wordsize-1:0] bus_wdata,
  output logic                bus_write_en,
  input  logic [wordsize-1:0] bus_rdata
);

  localparam int unsigned BURST_W = arb_cnt_width(max_burst);
  localparam int unsigned QUANT_W = arb_cnt_width(cpu_quantum);

  // Count value at which the current beat / CPU cycle is the last one needed
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(max_burst - 32'd1);
  localparam logic [QUANT_W-1:0] QUANT_LAST = QUANT_W'(cpu_quantum - 32'd1);

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic               waive_q;     // quantum waived until the first return after reset
  logic               waive_d;
  logic               rvalid_q;
  logic               rvalid_d;

  logic [BURST_W-1:0] burst_cnt_s;
  logic               burst_full_s;
  logic [QUANT_W-1:0] quant_cnt_s;
  logic               quant_full_s;
  logic               quant_ok_s;
  logic               gnt_s;
  logic               bus_sel_s;

  // Beats granted in the current master-1 tenure
  reflet_sat_counter #(
    .WIDTH (BURST_W),
    .LIMIT (max_burst)
  ) u_burst_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (state_q == ARB_DRAIN),
    .inc_i      (gnt_s),
    .count_o    (burst_cnt_s),
    .at_limit_o (burst_full_s)
  );

  // CPU-owned cycles since the last return
  reflet_sat_counter #(
    .WIDTH (QUANT_W),
    .LIMIT (cpu_quantum)
  ) u_quant_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (state_q == ARB_RETURN),
    .inc_i      (state_q == ARB_CPU_OWN),
    .count_o    (quant_cnt_s),
    .at_limit_o (quant_full_s)
  );

  // The decision is taken during the cycle that completes the quantum, so the
  // CPU gets exactly cpu_quantum cycles before the next drain.
  assign quant_ok_s = waive_q | quant_full_s | (quant_cnt_s == QUANT_LAST);

  // Next arbiter state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_CPU_OWN: begin
        if (m1_req && quant_ok_s) begin
          state_d = ARB_DRAIN;
        end else begin
          state_d = ARB_CPU_OWN;
        end
      end
      ARB_DRAIN: begin
        state_d = ARB_M1_OWN;
      end
      ARB_M1_OWN: begin
        if (!m1_req) begin
          state_d = ARB_RETURN;
        end else if (gnt_s && (burst_cnt_s == BURST_LAST)) begin
          state_d = ARB_RETURN;
        end else if (burst_full_s) begin
          // Unreachable in normal operation; never let master 1 hold the bus.
          state_d = ARB_RETURN;
        end else begin
          state_d = ARB_M1_OWN;
        end
      end
      ARB_RETURN: begin
        state_d = ARB_CPU_OWN;
      end
      default: begin
        state_d = ARB_CPU_OWN;
      end
    endcase
  end

  // Quantum waiver is consumed by the first return
  always_comb begin
    if (state_q == ARB_RETURN) begin
      waive_d = 1'b0;
    end else begin
      waive_d = waive_q;
    end
  end

  // Read data follows one cycle after any accepted read beat
  always_comb begin
    rvalid_d = gnt_s & ~m1_write_en;
  end

  // Arbiter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_CPU_OWN;
      waive_q  <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      waive_q  <= waive_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Address/data source: master 1 only while it owns the bus
  always_comb begin
    if (state_q == ARB_M1_OWN) begin
      bus_sel_s = ARB_M_1;
    end else begin
      bus_sel_s = ARB_M_CPU;
    end
  end

  // Address/data mux; drain and return keep the stalled CPU address on the bus
  always_comb begin
    if (bus_sel_s == ARB_M_1) begin
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
    end else begin
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
    end
  end

  // Per-state enable, grant and write strobe
  always_comb begin
    cpu_enable   = 1'b0;
    gnt_s        = 1'b0;
    bus_write_en = 1'b0;
    case (state_q)
      ARB_CPU_OWN: begin
        cpu_enable   = 1'b1;
        bus_write_en = cpu_write_en;
      end
      ARB_DRAIN: begin
        cpu_enable   = 1'b0;
        bus_write_en = 1'b0;
      end
      ARB_M1_OWN: begin
        gnt_s        = m1_req & ~burst_full_s;
        bus_write_en = m1_req & ~burst_full_s & m1_write_en;
      end
      ARB_RETURN: begin
        cpu_enable   = 1'b0;
        bus_write_en = 1'b0;
      end
      default: begin
        cpu_enable   = 1'b0;
        bus_write_en = 1'b0;
      end
    endcase
  end

  assign m1_gnt    = gnt_s;
  assign m1_rvalid = rvalid_q;
  assign m1_rdata  = bus_rdata;

endmodule : reflet_bus_arbiter

// File: tb/tb_reflet_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reflet_bus_arbiter
// Directed stimulus for reflet_bus_arbiter (wordsize 16, max_burst 8,
// cpu_quantum 4) with a small synchronous RAM model on the bus. Expected
// grants and read data are queued as stimulus is issued; a monitor pops and
// compares them whenever m1_gnt / m1_rvalid are seen.
// -----------------------------------------------------------------------------
module tb_reflet_bus_arbiter;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
  } beat_t;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_write_en;
  logic        cpu_enable;
  logic        m1_req;
  logic [15:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_write_en;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [15:0] m1_rdata;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_write_en;
  logic [15:0] bus_rdata;

  logic [15:0] mem [0:255];
  logic [15:0] rdata_r;
  logic        mem_init;

  beat_t       gnt_q[$];
  logic [15:0] rd_q[$];
  int          tests_run;
  int          tests_failed;

  reflet_bus_arbiter #(
    .wordsize    (16),
    .max_burst   (8),
    .cpu_quantum (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_write_en (cpu_write_en),
    .cpu_enable   (cpu_enable),
    .m1_req       (m1_req),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_write_en  (m1_write_en),
    .m1_gnt       (m1_gnt),
    .m1_rvalid    (m1_rvalid),
    .m1_rdata     (m1_rdata),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_write_en (bus_write_en),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM slave: word i preloaded with 16'hA000 + i, one-cycle read latency
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
      rdata_r <= 16'h0000;
    end else begin
      if (bus_write_en) mem[bus_addr[7:0]] <= bus_wdata;
      rdata_r <= mem[bus_addr[7:0]];
    end
  end
  assign bus_rdata = rdata_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT grants or returns data
  always @(negedge clk) begin
    beat_t b;
    if (reset === 1'b1) begin
      if (m1_gnt === 1'b1) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'd1, 32'd0);
        end else begin
          b = gnt_q.pop_front();
          check("gnt_addr", 32'(bus_addr), 32'(b.addr));
          check("gnt_we", 32'(bus_write_en), 32'(b.we));
          if (b.we) check("gnt_wdata", 32'(bus_wdata), 32'(b.wdata));
        end
      end
      if (m1_rvalid === 1'b1) begin
        if (rd_q.size() == 0) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          check("rvalid_data", 32'(m1_rdata), 32'(rd_q.pop_front()));
        end
      end
    end
  end

  // One cycle: check the CPU enable mid-cycle, then move to the next cycle
  task automatic step(input logic exp_en);
    @(negedge clk);
    check("cpu_enable", 32'(cpu_enable), 32'(exp_en));
    @(posedge clk);
    #1;
  endtask

  // Drain/return cycle with the CPU trying to write: strobe must be masked
  task automatic masked_step(input logic [15:0] a);
    cpu_addr     = a;
    cpu_wdata    = 16'hDEAD;
    cpu_write_en = 1'b1;
    @(negedge clk);
    check("stall_enable", 32'(cpu_enable), 32'd0);
    check("mask_write_en", 32'(bus_write_en), 32'd0);
    check("stall_addr", 32'(bus_addr), 32'(a));
    @(posedge clk);
    #1;
    cpu_write_en = 1'b0;
  endtask

  // Present one master-1 beat for a cycle that is expected to grant it
  task automatic beat(input logic [15:0] a, input logic we, input logic [15:0] d,
                      input logic [15:0] rexp);
    m1_req      = 1'b1;
    m1_addr     = a;
    m1_write_en = we;
    m1_wdata    = d;
    gnt_q.push_back(beat_t'{addr: a, we: we, wdata: d});
    if (!we) rd_q.push_back(rexp);
    step(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    mem_init     = 1'b1;
    cpu_addr     = 16'h0180;
    cpu_wdata    = 16'h0000;
    cpu_write_en = 1'b0;
    m1_req       = 1'b0;
    m1_addr      = 16'h0000;
    m1_wdata     = 16'h0000;
    m1_write_en  = 1'b0;

    // Reset values
    #3;
    check("reset_enable", 32'(cpu_enable), 32'd1);
    check("reset_gnt", 32'(m1_gnt), 32'd0);
    check("reset_rvalid", 32'(m1_rvalid), 32'd0);
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Idle: CPU owns the bus, its accesses pass straight through
    for (int i = 0; i < 20; i++) begin
      cpu_addr     = 16'h0180 + 16'(i);
      cpu_wdata    = 16'h0F00 + 16'(i);
      cpu_write_en = 1'(i % 2);
      @(negedge clk);
      check("idle_enable", 32'(cpu_enable), 32'd1);
      check("idle_addr", 32'(bus_addr), 32'(16'h0180 + 16'(i)));
      check("idle_wdata", 32'(bus_wdata), 32'(16'h0F00 + 16'(i)));
      check("idle_write_en", 32'(bus_write_en), 32'(i % 2));
      @(posedge clk); #1;
    end
    cpu_write_en = 1'b0;

    // Single read: quantum waived after reset, so drain follows at once
    m1_req      = 1'b1;
    m1_addr     = 16'h8010;
    m1_write_en = 1'b0;
    gnt_q.push_back(beat_t'{addr: 16'h8010, we: 1'b0, wdata: 16'h0000});
    rd_q.push_back(16'hA010);
    step(1'b1);          // CPU_OWN, request seen
    step(1'b0);          // DRAIN
    step(1'b0);          // M1_OWN, beat granted
    m1_req = 1'b0;
    step(1'b0);          // M1_OWN without request, read data returned
    step(1'b0);          // RETURN

    // Burst cap twice in a row with the request held; CPU writes masked
    for (int rep = 0; rep < 2; rep++) begin
      m1_req      = 1'b1;
      m1_addr     = 16'h8000;
      m1_write_en = 1'b1;
      m1_wdata    = 16'h1000;
      for (int q = 0; q < 4; q++) step(1'b1);   // CPU quantum
      masked_step(16'h8030);                    // DRAIN
      for (int k = 0; k < 8; k++) begin
        beat(16'h8000 + 16'(k), 1'b1, 16'(16'h1000 + rep * 256 + k), 16'h0000);
      end
      m1_addr = 16'h8000;
      masked_step(16'h8031);                    // RETURN
    end
    m1_req      = 1'b0;
    m1_write_en = 1'b0;

    // Early release after three reads
    m1_req  = 1'b1;
    m1_addr = 16'h8020;
    for (int q = 0; q < 4; q++) step(1'b1);
    step(1'b0);          // DRAIN
    for (int k = 0; k < 3; k++) begin
      beat(16'h8020 + 16'(k), 1'b0, 16'h0000, 16'hA020 + 16'(k));
    end
    m1_req = 1'b0;
    step(1'b0);          // M1_OWN without request, third read data
    step(1'b0);          // RETURN

    // Request withdrawn on M1_OWN entry: zero-beat tenure, return still taken
    m1_req  = 1'b1;
    m1_addr = 16'h8050;
    for (int q = 0; q < 4; q++) step(1'b1);
    step(1'b0);          // DRAIN
    m1_req = 1'b0;
    step(1'b0);          // M1_OWN, nothing granted
    step(1'b0);          // RETURN

    // Asynchronous reset in the middle of a read burst
    m1_req  = 1'b1;
    m1_addr = 16'h8040;
    for (int q = 0; q < 4; q++) step(1'b1);
    step(1'b0);          // DRAIN
    beat(16'h8040, 1'b0, 16'h0000, 16'hA040);
    m1_addr = 16'h8041;
    gnt_q.push_back(beat_t'{addr: 16'h8041, we: 1'b0, wdata: 16'h0000});
    step(1'b0);          // beat 1 granted; its read data is lost to the reset
    m1_addr = 16'h8042;  // beat 2 on the bus when reset hits
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_enable", 32'(cpu_enable), 32'd1);
    check("async_reset_gnt", 32'(m1_gnt), 32'd0);
    check("async_reset_rvalid", 32'(m1_rvalid), 32'd0);
    m1_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // After reset master 1 re-requests and is served without waiting a quantum
    m1_req  = 1'b1;
    m1_addr = 16'h8005;
    gnt_q.push_back(beat_t'{addr: 16'h8005, we: 1'b0, wdata: 16'h0000});
    rd_q.push_back(16'h1105);
    step(1'b1);
    step(1'b0);          // DRAIN
    step(1'b0);          // beat granted
    m1_req = 1'b0;
    step(1'b0);
    step(1'b0);          // RETURN
    step(1'b1);
    step(1'b1);

    // Everything queued was consumed; RAM shows burst writes, no CPU writes
    check("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("mem_masked_drain", 32'(mem[8'h30]), 32'(16'hA030));
    check("mem_masked_return", 32'(mem[8'h31]), 32'(16'hA031));
    for (int k = 0; k < 8; k++) begin
      check("mem_burst_word", 32'(mem[k]), 32'(16'h1100 + 16'(k)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_reflet_bus_arbiter
